// File: rtl/mul_pkg.sv
// Shared encodings for the iterative M-extension multiplier.
package mul_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/mul_pp_step.sv
// One radix step: adds ma * digit, shifted into place, to the running product.
module mul_pp_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 4,
  parameter int SW   = 6
) (
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   ma,
  input  logic [BPC-1:0]    digit,
  input  logic [SW-1:0]     shift,
  output logic [2*XLEN-1:0] acc_out
);

  localparam int W2 = 2 * XLEN;

  logic [W2-1:0] pp;

  always_comb begin
    pp      = W2'(ma) * W2'(digit);
    acc_out = acc_in + (pp << shift);
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative multiplier for MUL/MULH/MULHSU/MULHU with start/ready/done handshake,
// abort flush and a zero-operand shortcut straight to the sign-fix cycle.
module mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BPC  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            abort,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int N  = XLEN / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = $clog2(2 * XLEN);

  state_t state, state_nxt;

  logic [XLEN-1:0]   ma, mb;
  logic              neg, hi;
  logic [2*XLEN-1:0] acc, acc_nxt, p;
  logic [CW-1:0]     cnt;
  logic [SW-1:0]     shift;

  logic              accept, last;
  logic              sa, sb, a_neg, b_neg, neg_in, hi_in, zero_in;
  logic [XLEN-1:0]   ma_in, mb_in;

  assign accept = (state == IDLE) && start && !abort;
  assign last   = (cnt == CW'(N - 1));
  assign shift  = SW'(32'(cnt) * BPC);

  // Operands are reduced to magnitudes up front; the sign is reapplied in FIX.
  always_comb begin
    sa    = 1'b0;
    sb    = 1'b0;
    hi_in = 1'b1;
    case (op)
      OP_MULH: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      OP_MULHSU: sa = 1'b1;
      OP_MULHU:  hi_in = 1'b1;
      default:   hi_in = 1'b0;
    endcase
    a_neg   = sa & a[XLEN-1];
    b_neg   = sb & b[XLEN-1];
    ma_in   = a_neg ? -a : a;
    mb_in   = b_neg ? -b : b;
    neg_in  = a_neg ^ b_neg;
    zero_in = (ma_in == '0) || (mb_in == '0);
  end

  mul_pp_step #(
    .XLEN (XLEN),
    .BPC  (BPC),
    .SW   (SW)
  ) u_step (
    .acc_in  (acc),
    .ma      (ma),
    .digit   (mb[BPC-1:0]),
    .shift   (shift),
    .acc_out (acc_nxt)
  );

  assign p = neg ? -acc : acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_in ? FIX : CALC;
      CALC: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma     <= '0;
      mb     <= '0;
      neg    <= 1'b0;
      hi     <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            ma  <= ma_in;
            mb  <= mb_in;
            neg <= neg_in;
            hi  <= hi_in;
            acc <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          if (!abort) begin
            acc <= acc_nxt;
            mb  <= mb >> BPC;
            cnt <= cnt + CW'(1);
          end
        end
        FIX: begin
          if (!abort) begin
            result <= hi ? p[2*XLEN-1:XLEN] : p[XLEN-1:0];
            done   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter.sv
// Directed bench for mul_iter with a cycle-level reference model and per-cycle compare.
module tb_mul_iter;
  import mul_pkg::*;

  localparam int XLEN = 32;
  localparam int BPC  = 4;
  localparam int LAT  = XLEN / BPC + 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [2:0]      op_i = '0;
  logic [XLEN-1:0] a_i = '0;
  logic [XLEN-1:0] b_i = '0;
  logic            abort = 1'b0;
  logic            ready, done;
  logic [XLEN-1:0] result;

  int errors = 0;
  int checks = 0;

  mul_iter #(.XLEN(XLEN), .BPC(BPC)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op_i),
    .a      (a_i),
    .b      (b_i),
    .abort  (abort),
    .ready  (ready),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic from full-width signed/unsigned products.
  function automatic logic [31:0] ref_mul(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] pr;
    case (op)
      OP_MULH:   begin pr = 64'($signed(x)) * 64'($signed(y)); return pr[63:32]; end
      OP_MULHSU: begin pr = 64'($signed(x)) * 64'(y);          return pr[63:32]; end
      OP_MULHU:  begin pr = 64'(x) * 64'(y);                   return pr[63:32]; end
      default:   begin pr = 64'(x) * 64'(y);                   return pr[31:0];  end
    endcase
  endfunction

  logic            m_busy = 1'b0;
  logic            m_done = 1'b0;
  int              m_left = 0;
  logic [XLEN-1:0] m_res  = '0;
  logic [XLEN-1:0] m_held = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_held <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (abort) m_busy <= 1'b0;
        else if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_held <= m_res;
        end else m_left <= m_left - 1;
      end else if (start && !abort) begin
        m_busy <= 1'b1;
        m_res  <= ref_mul(op_i, a_i, b_i);
        m_left <= (a_i == '0 || b_i == '0) ? 1 : LAT;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("ready", 64'(ready), 64'(!m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("result", 64'(result), 64'(m_held));
    end
  end

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp, input int lat, input bit pulse, input string name);
    int n;
    op_i  = op;
    a_i   = x;
    b_i   = y;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a_i   = $urandom;
    b_i   = $urandom;
    n     = 0;
    while (done !== 1'b1 && n < 30) begin
      if (pulse && n == 3) begin
        start = 1'b1;
        op_i  = OP_MUL;
        a_i   = 32'd100;
        b_i   = 32'd100;
      end else start = 1'b0;
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({name, " latency"}, 64'(n), 64'(lat));
    chk({name, " value"}, 64'(result), 64'(exp));
    chk({name, " ready@done"}, 64'(ready), 64'd1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst ready", 64'(ready), 64'd1);
    chk("rst done", 64'(done), 64'd0);
    chk("rst result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op(OP_MUL,    32'd7,          32'd6,          32'd42,         9, 1'b0, "mul7x6");
    run_op(OP_MULH,   32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  9, 1'b0, "mulh_m1x2");
    run_op(OP_MULHU,  32'hFFFF_FFFF,  32'd2,          32'h0000_0001,  9, 1'b0, "mulhu_m1x2");
    run_op(OP_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  9, 1'b0, "mulhsu_min");
    run_op(OP_MULH,   32'h8000_0000,  32'h8000_0000,  32'h4000_0000,  9, 1'b0, "mulh_minxmin");
    run_op(OP_MUL,    32'h8000_0000,  32'h8000_0000,  32'h0000_0000,  9, 1'b0, "mul_minxmin");
    run_op(3'b110,    32'd5,          32'd7,          32'd35,         9, 1'b0, "op1xx_as_mul");
    run_op(OP_MUL,    32'd0,          32'h1234_5678,  32'd0,          1, 1'b0, "mul_zero");
    run_op(OP_MUL,    32'd3,          32'd5,          32'd15,         9, 1'b0, "mul3x5_b2b");

    // Abort sampled on the third edge after accept.
    op_i = OP_MUL; a_i = 32'd7; b_i = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort calc ready", 64'(ready), 64'd1);
    chk("abort calc done", 64'(done), 64'd0);
    chk("abort calc result", 64'(result), 64'd15);

    run_op(OP_MUL, 32'd9, 32'd9, 32'd81, 9, 1'b1, "mul9x9_ignore_start");

    // Abort coinciding with the sign-fix edge.
    op_i = OP_MUL; a_i = 32'd5; b_i = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort fix done", 64'(done), 64'd0);
    chk("abort fix ready", 64'(ready), 64'd1);
    chk("abort fix result", 64'(result), 64'd81);

    op_i = OP_MUL; a_i = 32'd2; b_i = 32'd2; start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort idle ready", 64'(ready), 64'd1);
    @(negedge clk);
    chk("abort idle result", 64'(result), 64'd81);

    op_i = OP_MUL; a_i = 32'd7; b_i = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async rst ready", 64'(ready), 64'd1);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_op(OP_MUL, 32'd2, 32'd2, 32'd4, 9, 1'b0, "mul2x2_after_rst");

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
